// File: rtl/sram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_rr_arbiter
// Purpose  : Two-requester round-robin arbiter onto one single-port 33-bit
//            SRAM macro port. Define SRAM_ARB_INIT_EN to clear words
//            0..511 on every exit from reset.
// Revision : 1.0
// ============================================================================
module sram_rr_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk0,
    input  logic          rst0,

    input  logic          m0_req_valid,
    output logic          m0_req_ready,
    input  logic          m0_we,
    input  logic [3:0]    m0_be,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req_valid,
    output logic          m1_req_ready,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          init_done,

    output logic          sram_csb0,
    output logic          sram_web0,
    output logic [3:0]    sram_wmask0,
    output logic          sram_spare_wen0,
    output logic [9:0]    sram_addr0,
    output logic [32:0]   sram_din0,
    input  logic [32:0]   sram_dout0
);

    localparam int c_MACRO_AW = 10;
    localparam int c_MACRO_DW = 33;

    typedef enum logic [0:0] {
        c_ST_INIT = 1'b0,
        c_ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state_q, w_state_d;
    logic                    r_ptr_q, w_ptr_d;
    logic                    r_init_done_q, w_init_done_d;
    logic                    r_csb_q, w_csb_d;
    logic                    r_web_q, w_web_d;
    logic [3:0]              r_wmask_q, w_wmask_d;
    logic                    r_spare_q, w_spare_d;
    logic [c_MACRO_AW-1:0]   r_addr_q, w_addr_d;
    logic [c_MACRO_DW-1:0]   r_din_q, w_din_d;
    logic                    r_rd_vld1_q, w_rd_vld1_d;
    logic                    r_rd_own1_q, w_rd_own1_d;
    logic                    r_rd_vld2_q, w_rd_vld2_d;
    logic                    r_rd_own2_q, w_rd_own2_d;
    logic                    r_rvalid0_q, w_rvalid0_d;
    logic                    r_rvalid1_q, w_rvalid1_d;
    logic [DW-1:0]           r_rdata0_q, w_rdata0_d;
    logic [DW-1:0]           r_rdata1_q, w_rdata1_d;
`ifdef SRAM_ARB_INIT_EN
    logic [8:0]              r_init_cnt_q, w_init_cnt_d;
`endif

    logic                    w_run;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_acc0;
    logic                    w_acc1;
    logic                    w_acc;
    logic                    w_sel_we;
    logic [3:0]              w_sel_be;
    logic [AW-1:0]           w_sel_addr;
    logic [DW-1:0]           w_sel_wdata;
    logic                    w_unused_dout;

    // r_ptr_q=0 favours m0 on contention, 1 favours m1.
    assign w_run        = (r_state_q == c_ST_RUN);
    assign w_gnt0       = m0_req_valid && (!m1_req_valid || !r_ptr_q);
    assign w_gnt1       = m1_req_valid && (!m0_req_valid ||  r_ptr_q);
    assign m0_req_ready = w_run && w_gnt0;
    assign m1_req_ready = w_run && w_gnt1;
    assign w_acc0       = m0_req_valid && m0_req_ready;
    assign w_acc1       = m1_req_valid && m1_req_ready;
    assign w_acc        = w_acc0 || w_acc1;

    assign w_sel_we     = w_acc1 ? m1_we    : m0_we;
    assign w_sel_be     = w_acc1 ? m1_be    : m0_be;
    assign w_sel_addr   = w_acc1 ? m1_addr  : m0_addr;
    assign w_sel_wdata  = w_acc1 ? m1_wdata : m0_wdata;

    assign w_unused_dout = ^sram_dout0;

    always_comb begin
        w_state_d     = r_state_q;
        w_ptr_d       = r_ptr_q;
        w_init_done_d = r_init_done_q;
        w_csb_d       = r_csb_q;
        w_web_d       = r_web_q;
        w_wmask_d     = r_wmask_q;
        w_spare_d     = r_spare_q;
        w_addr_d      = r_addr_q;
        w_din_d       = r_din_q;
        w_rd_vld1_d   = 1'b0;
        w_rd_own1_d   = r_rd_own1_q;
`ifdef SRAM_ARB_INIT_EN
        w_init_cnt_d  = r_init_cnt_q;
`endif

        case (r_state_q)
            c_ST_INIT: begin
`ifdef SRAM_ARB_INIT_EN
                w_csb_d      = 1'b0;
                w_web_d      = 1'b0;
                w_wmask_d    = 4'hF;
                w_spare_d    = 1'b1;
                w_addr_d     = {1'b0, r_init_cnt_q};
                w_din_d      = '0;
                w_init_cnt_d = r_init_cnt_q + 9'd1;
                if (r_init_cnt_q == 9'h1FF) begin
                    w_state_d     = c_ST_RUN;
                    w_init_done_d = 1'b1;
                end
`else
                w_state_d     = c_ST_RUN;
                w_init_done_d = 1'b1;
`endif
            end
            default: begin
                if (w_acc) begin
                    w_csb_d     = 1'b0;
                    w_web_d     = ~w_sel_we;
                    w_wmask_d   = w_sel_we ? w_sel_be : 4'h0;
                    w_spare_d   = 1'b0;
                    w_addr_d    = c_MACRO_AW'(w_sel_addr);
                    w_din_d     = c_MACRO_DW'(w_sel_wdata);
                    w_ptr_d     = ~w_acc1;
                    w_rd_vld1_d = ~w_sel_we;
                    w_rd_own1_d = w_acc1;
                end else begin
                    w_csb_d     = 1'b1;
                    w_web_d     = 1'b1;
                    w_wmask_d   = 4'h0;
                    w_spare_d   = 1'b0;
                end
            end
        endcase

        // Macro samples pins one edge after issue; data is taken the edge after.
        w_rd_vld2_d = r_rd_vld1_q;
        w_rd_own2_d = r_rd_own1_q;
        w_rvalid0_d = r_rd_vld2_q && !r_rd_own2_q;
        w_rvalid1_d = r_rd_vld2_q &&  r_rd_own2_q;
        w_rdata0_d  = w_rvalid0_d ? sram_dout0[DW-1:0] : r_rdata0_q;
        w_rdata1_d  = w_rvalid1_d ? sram_dout0[DW-1:0] : r_rdata1_q;
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state_q     <= c_ST_INIT;
            r_ptr_q       <= 1'b0;
            r_init_done_q <= 1'b0;
            r_csb_q       <= 1'b1;
            r_web_q       <= 1'b1;
            r_wmask_q     <= 4'h0;
            r_spare_q     <= 1'b0;
            r_addr_q      <= '0;
            r_din_q       <= '0;
            r_rd_vld1_q   <= 1'b0;
            r_rd_own1_q   <= 1'b0;
            r_rd_vld2_q   <= 1'b0;
            r_rd_own2_q   <= 1'b0;
            r_rvalid0_q   <= 1'b0;
            r_rvalid1_q   <= 1'b0;
            r_rdata0_q    <= '0;
            r_rdata1_q    <= '0;
`ifdef SRAM_ARB_INIT_EN
            r_init_cnt_q  <= '0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_ptr_q       <= w_ptr_d;
            r_init_done_q <= w_init_done_d;
            r_csb_q       <= w_csb_d;
            r_web_q       <= w_web_d;
            r_wmask_q     <= w_wmask_d;
            r_spare_q     <= w_spare_d;
            r_addr_q      <= w_addr_d;
            r_din_q       <= w_din_d;
            r_rd_vld1_q   <= w_rd_vld1_d;
            r_rd_own1_q   <= w_rd_own1_d;
            r_rd_vld2_q   <= w_rd_vld2_d;
            r_rd_own2_q   <= w_rd_own2_d;
            r_rvalid0_q   <= w_rvalid0_d;
            r_rvalid1_q   <= w_rvalid1_d;
            r_rdata0_q    <= w_rdata0_d;
            r_rdata1_q    <= w_rdata1_d;
`ifdef SRAM_ARB_INIT_EN
            r_init_cnt_q  <= w_init_cnt_d;
`endif
        end
    end

    assign init_done       = r_init_done_q;
    assign sram_csb0       = r_csb_q;
    assign sram_web0       = r_web_q;
    assign sram_wmask0     = r_wmask_q;
    assign sram_spare_wen0 = r_spare_q;
    assign sram_addr0      = r_addr_q;
    assign sram_din0       = r_din_q;
    assign m0_rvalid       = r_rvalid0_q;
    assign m1_rvalid       = r_rvalid1_q;
    assign m0_rdata        = r_rdata0_q;
    assign m1_rdata        = r_rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_rr_arbiter
// Purpose  : Directed and random bench for sram_rr_arbiter with a behavioural
//            SRAM macro and a read-response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sram_rr_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          m0_req_valid = 1'b0, m1_req_valid = 1'b0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]    m0_be = 4'h0, m1_be = 4'h0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_req_ready, m1_req_ready;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          init_done;
    logic          sram_csb0, sram_web0, sram_spare_wen0;
    logic [3:0]    sram_wmask0;
    logic [9:0]    sram_addr0;
    logic [32:0]   sram_din0;
    logic [32:0]   sram_dout0 = '0;

    int n_checks = 0;
    int n_errors = 0;
    longint cyc = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
        longint      due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] ref_mem [0:511];

    task automatic chk(input string tag, input bit ok, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always #5 clk0 = ~clk0;
    always @(posedge clk0) cyc <= cyc + 1;

    sram_rr_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk0(clk0), .rst0(rst0),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_we(m0_we),
        .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_we(m1_we),
        .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_spare_wen0(sram_spare_wen0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // Behavioural macro: pins sampled at the rising edge, dout valid after it.
    logic [32:0] mem [0:1023];
    bit filled = 1'b0;

    function automatic logic [32:0] merge(input logic [32:0] old, input logic [32:0] din,
                                          input logic [3:0] wm, input logic spare);
        logic [32:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (wm[b]) w[b*8 +: 8] = din[b*8 +: 8];
        if (spare) w[32] = din[32];
        return w;
    endfunction

    always @(posedge clk0) begin
        if (!filled) begin
            for (int i = 0; i < 1024; i++) mem[i] <= {1'b1, $urandom()};
            filled <= 1'b1;
        end else if (!sram_csb0) begin
            if (!sram_web0)
                mem[sram_addr0] <= merge(mem[sram_addr0], sram_din0, sram_wmask0, sram_spare_wen0);
            else
                sram_dout0 <= mem[sram_addr0];
        end
    end

    // Response monitor: every strobe must match the oldest expected read.
    always @(negedge clk0) begin
        if (m0_rvalid || m1_rvalid) begin
            chk("rv_exclusive", (m0_rvalid && m1_rvalid) === 1'b0, (m0_rvalid && m1_rvalid), 1'b0);
            chk("rv_expected", (sb.size() > 0) === 1'b1, (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rv_port", m1_rvalid === mon_e.port, m1_rvalid, mon_e.port);
                chk("rv_data", (mon_e.port ? m1_rdata : m0_rdata) === mon_e.data,
                    (mon_e.port ? m1_rdata : m0_rdata), mon_e.data);
                chk("rv_latency", cyc === mon_e.due, cyc, mon_e.due);
            end
        end
    end

    task automatic push_read(input bit port, input logic [8:0] addr);
        exp_t e;
        e.port = port;
        e.data = ref_mem[addr];
        e.due  = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic issue(input bit port, input bit we, input logic [3:0] be,
                         input logic [8:0] addr, input logic [31:0] data);
        int waited = 0;
        bit got = 1'b0;
        @(negedge clk0);
        if (!port) begin
            m0_req_valid = 1'b1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = data;
        end else begin
            m1_req_valid = 1'b1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = data;
        end
        while (!got && waited < 1000) begin
            #1;
            if (port ? m1_req_ready : m0_req_ready) got = 1'b1;
            else begin @(negedge clk0); waited++; end
        end
        chk("ready_timeout", got === 1'b1, got, 1'b1);
        if (got) begin
            if (!we) push_read(port, addr);
            else for (int b = 0; b < 4; b++) if (be[b]) ref_mem[addr][b*8 +: 8] = data[b*8 +: 8];
            @(posedge clk0);
            #1;
        end
        if (!port) m0_req_valid = 1'b0; else m1_req_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_csb0", sram_csb0 === 1'b1, sram_csb0, 1'b1);
        chk("rst_web0", sram_web0 === 1'b1, sram_web0, 1'b1);
        chk("rst_wmask0", sram_wmask0 === 4'h0, sram_wmask0, 4'h0);
        chk("rst_spare", sram_spare_wen0 === 1'b0, sram_spare_wen0, 1'b0);
        chk("rst_addr0", sram_addr0 === 10'h0, sram_addr0, 10'h0);
        chk("rst_din0", sram_din0 === 33'h0, sram_din0, 33'h0);
        chk("rst_ready", {m0_req_ready, m1_req_ready} === 2'b00, {m0_req_ready, m1_req_ready}, 2'b00);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid} === 2'b00, {m0_rvalid, m1_rvalid}, 2'b00);
        chk("rst_rdata0", m0_rdata === 32'h0, m0_rdata, 32'h0);
        chk("rst_rdata1", m1_rdata === 32'h0, m1_rdata, 32'h0);
        chk("rst_init_done", init_done === 1'b0, init_done, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk0);
        chk("sb_drain", sb.size() === 0, sb.size(), 0);
    endtask

    task automatic do_reset(input int n);
        bit ok = 1'b0;
        @(negedge clk0);
        rst0 = 1'b1;
        repeat (n) @(negedge clk0);
        #1;
        check_reset_vals();
        rst0 = 1'b0;
        @(posedge clk0);
        #1;
`ifdef SRAM_ARB_INIT_EN
        chk("reinit_csb0", sram_csb0 === 1'b0, sram_csb0, 1'b0);
        chk("reinit_addr0", sram_addr0 === 10'h0, sram_addr0, 10'h0);
        chk("reinit_done", init_done === 1'b0, init_done, 1'b0);
        for (int i = 0; i < 1000; i++) ref_mem[i%512] = 32'h0;
`else
        chk("noinit_done", init_done === 1'b1, init_done, 1'b1);
        chk("noinit_csb0", sram_csb0 === 1'b1, sram_csb0, 1'b1);
`endif
        for (int i = 0; i < 600 && !ok; i++) begin
            if (init_done) ok = 1'b1;
            else begin @(posedge clk0); #1; end
        end
        chk("init_timeout", ok === 1'b1, ok, 1'b1);
    endtask

    initial begin
        logic [8:0] a0, a1;
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;

        // Reset
`ifdef SRAM_ARB_INIT_EN
        m0_req_valid = 1'b1; m0_we = 1'b0; m0_addr = 9'h1FF;
`endif
        repeat (3) @(negedge clk0);
        #1;
        check_reset_vals();
        rst0 = 1'b0;

`ifdef SRAM_ARB_INIT_EN
        for (int k = 1; k <= 512; k++) begin
            chk("init_ready", m0_req_ready === 1'b0, m0_req_ready, 1'b0);
            chk("init_done_lo", init_done === 1'b0, init_done, 1'b0);
            @(posedge clk0);
            #1;
            chk("init_addr0", sram_addr0 === 10'(k - 1), sram_addr0, 10'(k - 1));
            chk("init_pins", {sram_csb0, sram_web0, sram_wmask0, sram_spare_wen0} === 7'b00_1111_1,
                {sram_csb0, sram_web0, sram_wmask0, sram_spare_wen0}, 7'b00_1111_1);
            chk("init_din0", sram_din0 === 33'h0, sram_din0, 33'h0);
            @(negedge clk0);
        end
        #1;
        chk("init_done_hi", init_done === 1'b1, init_done, 1'b1);
        chk("first_ready", m0_req_ready === 1'b1, m0_req_ready, 1'b1);
        push_read(1'b0, 9'h1FF);
        @(posedge clk0);
        #1;
        m0_req_valid = 1'b0;
`else
        chk("pre_edge1_done", init_done === 1'b0, init_done, 1'b0);
        @(posedge clk0);
        #1;
        chk("edge1_done", init_done === 1'b1, init_done, 1'b1);
        chk("edge1_no_write", sram_csb0 === 1'b1, sram_csb0, 1'b1);
`endif

        // Write then read back, pin encoding on each accept and on idle
        issue(1'b0, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF);
        chk("wr_pins", {sram_csb0, sram_web0, sram_wmask0, sram_spare_wen0} === 7'b00_1111_0,
            {sram_csb0, sram_web0, sram_wmask0, sram_spare_wen0}, 7'b00_1111_0);
        chk("wr_addr0", sram_addr0 === 10'h005, sram_addr0, 10'h005);
        chk("wr_din0", sram_din0 === 33'h0_DEAD_BEEF, sram_din0, 33'h0_DEAD_BEEF);
        issue(1'b0, 1'b0, 4'hF, 9'h005, 32'h0);
        chk("rd_pins", {sram_csb0, sram_web0, sram_wmask0} === 6'b01_0000,
            {sram_csb0, sram_web0, sram_wmask0}, 6'b01_0000);
        @(posedge clk0);
        #1;
        chk("idle_pins", {sram_csb0, sram_web0, sram_wmask0} === 6'b11_0000,
            {sram_csb0, sram_web0, sram_wmask0}, 6'b11_0000);
        chk("idle_addr_hold", sram_addr0 === 10'h005, sram_addr0, 10'h005);

        // Byte-enable merge and read-after-write at the next accept
        issue(1'b1, 1'b1, 4'hF, 9'h0A0, 32'h11223344);
        issue(1'b1, 1'b1, 4'b0100, 9'h0A0, 32'hAABBCCDD);
        issue(1'b1, 1'b0, 4'h0, 9'h0A0, 32'h0);

        // Zero byte-enable write is issued but changes nothing
        issue(1'b0, 1'b1, 4'h0, 9'h0A0, 32'hFFFFFFFF);
        chk("be0_pins", {sram_csb0, sram_web0, sram_wmask0} === 6'b00_0000,
            {sram_csb0, sram_web0, sram_wmask0}, 6'b00_0000);
        issue(1'b0, 1'b0, 4'h0, 9'h0A0, 32'h0);

        // Contention: last accept is m1 so the pointer favours m0
        issue(1'b0, 1'b1, 4'hF, 9'h010, 32'hA0A0A0A0);
        issue(1'b1, 1'b1, 4'hF, 9'h011, 32'hB1B1B1B1);
        issue(1'b0, 1'b1, 4'hF, 9'h012, 32'hC2C2C2C2);
        issue(1'b1, 1'b1, 4'hF, 9'h013, 32'hD3D3D3D3);
        a0 = 9'h010;
        a1 = 9'h011;
        @(negedge clk0);
        m0_req_valid = 1'b1; m0_we = 1'b0; m0_addr = a0;
        m1_req_valid = 1'b1; m1_we = 1'b0; m1_addr = a1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_m0_ready", m0_req_ready === (i % 2 == 0), m0_req_ready, (i % 2 == 0));
            chk("rr_m1_ready", m1_req_ready === (i % 2 == 1), m1_req_ready, (i % 2 == 1));
            if (i % 2 == 0) push_read(1'b0, a0); else push_read(1'b1, a1);
            @(posedge clk0);
            #1;
            if (i % 2 == 0) begin a0 = 9'h012; m0_addr = a0; end
            else begin a1 = 9'h013; m1_addr = a1; end
            @(negedge clk0);
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;

        // Random back-to-back mixed traffic on a small address window
        for (int i = 0; i < 8; i++)
            issue(1'($urandom_range(1)), 1'b1, 4'hF, 9'h100 + 9'(i), $urandom());
        for (int i = 0; i < 40; i++)
            issue(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)),
                  9'h100 + 9'($urandom_range(7)), $urandom());
        drain();

        // Reset one cycle after a read accept discards that read
        issue(1'b0, 1'b0, 4'h0, 9'h005, 32'h0);
        void'(sb.pop_back());
        do_reset(3);

        // Pointer restarts at m0
        @(negedge clk0);
        m0_req_valid = 1'b1; m0_we = 1'b0; m0_addr = 9'h005;
        m1_req_valid = 1'b1; m1_we = 1'b0; m1_addr = 9'h0A0;
        #1;
        chk("post_rst_m0", {m0_req_ready, m1_req_ready} === 2'b10, {m0_req_ready, m1_req_ready}, 2'b10);
        push_read(1'b0, 9'h005);
        @(posedge clk0);
        #1;
        m0_req_valid = 1'b0;
        @(negedge clk0);
        #1;
        chk("post_rst_m1", {m0_req_ready, m1_req_ready} === 2'b01, {m0_req_ready, m1_req_ready}, 2'b01);
        push_read(1'b1, 9'h0A0);
        @(posedge clk0);
        #1;
        m1_req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
